fifo_read_sequencer: RTL

Read-side controller for the asynchronous FIFO in the I2C-APB interface. On a start command it pops a programmed number of bytes from the FIFO read port (`read_increment` / `read_empty` / `read_data`) and presents them one at a time to the downstream I2C byte engine over a valid/ready handshake. It tracks the bytes delivered, ends the transfer on an underrun timeout or an abort, and reports completion status. It sits in the `read_clk` domain between the FIFO read pointer/empty logic and the I2C transmit engine.

---
 rtl/fifo_read_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_read_sequencer.sv
// fifo_read_sequencer
//   Read-side controller for the asynchronous FIFO of the I2C-APB interface.
//   On an accepted start it pops byte_count words from the FIFO read port and
//   presents them one at a time to the I2C byte engine over valid/ready.
//   A transfer ends after the last handshake (status 00), after stall_limit
//   consecutive empty cycles while fetching (status 01), or on abort
//   (status 10). done pulses for one cycle on the edge that returns to IDLE.
//
// Ports
//   read_clk        clock, rising edge
//   read_reset      asynchronous active-high reset
//   start           one-cycle command, acted on only while idle
//   byte_count      transfer length, sampled with start
//   abort           terminates an active transfer
//   read_empty      FIFO empty flag (registered inside the FIFO)
//   read_data       FIFO word at the read address, valid while not empty
//   read_increment  FIFO pop strobe (combinational)
//   byte_data       registered byte presented to the I2C engine
//   byte_valid      byte_data is valid
//   byte_ready      I2C engine accepts the byte
//   busy            transfer in progress
//   done            one-cycle end-of-transfer pulse
//   status          00 ok, 01 underrun, 10 aborted; held until next start
//   bytes_sent      handshakes completed in the current or last transfer

module fifo_read_sequencer #(
  parameter int data_width  = 8,
  parameter int count_width = 8,
  parameter int stall_limit = 255   // must be at least 1
) (
  input  logic                   read_clk,
  input  logic                   read_reset,
  input  logic                   start,
  input  logic [count_width-1:0] byte_count,
  input  logic                   abort,
  input  logic                   read_empty,
  input  logic [data_width-1:0]  read_data,
  output logic                   read_increment,
  output logic [data_width-1:0]  byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [count_width-1:0] bytes_sent
);

  localparam int stall_width = (stall_limit < 2) ? 1 : $clog2(stall_limit + 1);
  // Value of the stall counter during the empty cycle that completes the limit.
  localparam logic [stall_width-1:0] stall_last = stall_width'(stall_limit - 1);

  localparam logic [1:0] status_ok       = 2'b00;
  localparam logic [1:0] status_underrun = 2'b01;
  localparam logic [1:0] status_aborted  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [count_width-1:0] remaining;
  logic [stall_width-1:0] stall_count;

  logic in_fetch;
  logic in_present;
  logic accept;
  logic zero_start;
  logic handshake;
  logic last_byte;
  logic stall_tick;
  logic finish_ok;
  logic finish_underrun;
  logic finish_abort;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!read_empty) begin
          state_next = PRESENT;
        end else if (finish_underrun) begin
          state_next = IDLE;
        end
      end
      PRESENT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (handshake) begin
          if (last_byte) begin
            state_next = IDLE;
          end else if (read_empty) begin
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_fetch        = (state == FETCH);
    in_present      = (state == PRESENT);
    busy            = (state != IDLE);
    accept          = (state == IDLE) && start && (byte_count != '0);
    zero_start      = (state == IDLE) && start && (byte_count == '0);
    finish_abort    = (in_fetch || in_present) && abort;
    // A handshake coinciding with abort is dropped, so it never counts.
    handshake       = in_present && byte_valid && byte_ready && !abort;
    last_byte       = (remaining == count_width'(1));
    finish_ok       = handshake && last_byte;
    stall_tick      = in_fetch && read_empty && !abort;
    finish_underrun = stall_tick && (stall_count == stall_last);
    // Pops are gated by read_empty here rather than trusting the FIFO to
    // ignore a pop while empty; the PRESENT pop refills behind the handshake.
    read_increment  = !read_empty && !abort &&
                      (in_fetch || (handshake && !last_byte));
  end

  // ---------------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      done        <= 1'b0;
      status      <= status_ok;
      bytes_sent  <= '0;
      remaining   <= '0;
      stall_count <= '0;
    end else begin
      done <= finish_ok || finish_underrun || finish_abort || zero_start;

      if (accept) begin
        remaining   <= byte_count;
        bytes_sent  <= '0;
        status      <= status_ok;
        stall_count <= '0;
      end

      if (zero_start) begin
        bytes_sent <= '0;
        status     <= status_ok;
      end

      if (handshake) begin
        bytes_sent <= bytes_sent + count_width'(1);
        if (remaining != '0) begin
          remaining <= remaining - count_width'(1);
        end
      end

      if (read_increment) begin
        byte_data   <= read_data;
        stall_count <= '0;
      end else if (stall_tick) begin
        stall_count <= stall_count + stall_width'(1);
      end

      if (read_increment) begin
        byte_valid <= 1'b1;
      end else if (handshake || finish_abort) begin
        byte_valid <= 1'b0;
      end

      if (finish_underrun) begin
        status <= status_underrun;
      end else if (finish_abort) begin
        status <= status_aborted;
      end
    end
  end

endmodule
